// File: rtl/dpram_pkg.sv
// Shared constants and types for the parametrised dual-port RAM.
package dpram_pkg;

  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;

  typedef enum logic {CLEAR, RUN} state_t;

endpackage

// File: rtl/dpram_out_stage.sv
// Per-port read output stage: data capture, optional extra register and the
// matching valid pipeline.
module dpram_out_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic [STAGES-1:0]     vld_pipe;
  logic [DATA_WIDTH-1:0] d1;

  // Data registers load only on a valid access so the output holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      d1       <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (in_vld) d1 <= in_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] d2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)              d2 <= '0;
        else if (vld_pipe[0]) d2 <= d1;
      end
      assign out_data = d2;
    end else begin : g_noreg
      assign out_data = d1;
    end
  endgenerate

  assign out_vld = vld_pipe[STAGES-1];

endmodule

// File: rtl/dual_port_ram_param.sv
// Single-clock true dual-port RAM with post-reset clear, read-during-write
// mode selection, cross-port forwarding and same-address collision flag.
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter int                  DATA_WIDTH     = 8,
  parameter int                  ADDR_WIDTH     = 15,
  parameter int                  RW_MODE        = 0,
  parameter int                  OUT_REG        = 0,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_1,
  input  logic                  en_2,
  input  logic                  we_1,
  input  logic                  we_2,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  valid_1,
  output logic                  valid_2,
  output logic                  collision,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit WF    = (RW_MODE == RW_WRITE_FIRST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  clr_we;
  logic                  ready_q;
  logic                  coll_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == RUN);
      if (clr_we) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (&cnt) state_nxt = RUN;
      end
      RUN: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Requests count only once ready is up, which also masks them during clear.
  logic acc_1, acc_2, wr_1, wr_2, same_addr;
  assign acc_1     = en_1 & ready_q;
  assign acc_2     = en_2 & ready_q;
  assign wr_1      = acc_1 & we_1;
  assign wr_2      = acc_2 & we_2;
  assign same_addr = (addr_1 == addr_2);

  // Port 1 wins a same-address double write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= INIT_VALUE;
    end else begin
      if (wr_2 && !(wr_1 && same_addr)) mem[addr_2] <= data_in_2;
      if (wr_1)                         mem[addr_1] <= data_in_1;
    end
  end

  logic [1:0]                 acc;
  logic [1:0][DATA_WIDTH-1:0] rd, dout;
  logic [1:0]                 vld;

  always_comb begin
    rd[0] = mem[addr_1];
    rd[1] = mem[addr_2];
    if (WF) begin
      if (wr_1)                   rd[0] = data_in_1;
      else if (wr_2 && same_addr) rd[0] = data_in_2;
      if (wr_2)                   rd[1] = data_in_2;
      else if (wr_1 && same_addr) rd[1] = data_in_1;
    end
  end

  assign acc = {acc_2, acc_1};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_port
      dpram_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
      ) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (acc[g]),
        .in_data  (rd[g]),
        .out_vld  (vld[g]),
        .out_data (dout[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= acc_1 & acc_2 & same_addr & (we_1 | we_2);
  end

  assign data_out_1 = dout[0];
  assign data_out_2 = dout[1];
  assign valid_1    = vld[0];
  assign valid_2    = vld[1];
  assign collision  = coll_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench: two RAM instances (read-first/no out reg, write-first/out reg) on
// shared stimulus, checked against a reference memory and scoreboard.
module tb_dual_port_ram_param;

  localparam int DEPTH = 16;

  typedef struct {
    logic       e1, w1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       e2, w2;
    logic [3:0] a2;
    logic [7:0] d2;
    logic [7:0] x2_rf, x2_wf;
    logic       xcoll;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic       clk, rst;
  logic       en_1, en_2, we_1, we_2;
  logic [3:0] addr_1, addr_2;
  logic [7:0] data_in_1, data_in_2;
  logic [7:0] do_a1, do_a2, do_b1, do_b2;
  logic       va1, va2, vb1, vb2, coll_a, coll_b, rdy_a, rdy_b;

  dual_port_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RW_MODE(0), .OUT_REG(0),
                        .CLEAR_ON_RESET(1), .INIT_VALUE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .en_1(en_1), .en_2(en_2), .we_1(we_1), .we_2(we_2),
    .addr_1(addr_1), .addr_2(addr_2), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .data_out_1(do_a1), .data_out_2(do_a2), .valid_1(va1), .valid_2(va2),
    .collision(coll_a), .ready(rdy_a));

  dual_port_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RW_MODE(1), .OUT_REG(1),
                        .CLEAR_ON_RESET(1), .INIT_VALUE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .en_1(en_1), .en_2(en_2), .we_1(we_1), .we_2(we_2),
    .addr_1(addr_1), .addr_2(addr_2), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .data_out_1(do_b1), .data_out_2(do_b2), .valid_1(vb1), .valid_2(vb2),
    .collision(coll_b), .ready(rdy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         cyc = 0;
  int         rel_edges = 0;
  logic [7:0] mem_m [DEPTH];
  logic [7:0] last [4];
  exp_t       sbq [4][$];
  int         coll_q [$];
  vec_t       tab [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic e1, w1, input logic [3:0] a1, input logic [7:0] d1,
                               input logic e2, w2, input logic [3:0] a2, input logic [7:0] d2,
                               input logic [7:0] x2_rf, x2_wf, input logic xcoll);
    vec_t v;
    v.e1 = e1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e2 = e2; v.w2 = w2; v.a2 = a2; v.d2 = d2;
    v.x2_rf = x2_rf; v.x2_wf = x2_wf; v.xcoll = xcoll;
    return v;
  endfunction

  // Reference read result for port p under read-first (wf=0) or write-first.
  function automatic logic [7:0] mdl_rd(input int p, input bit wf, input vec_t v);
    logic       mw, ow;
    logic [3:0] ma, oa;
    logic [7:0] md, od;
    if (p == 1) begin
      mw = v.w1; ma = v.a1; md = v.d1; ow = v.e2 && v.w2; oa = v.a2; od = v.d2;
    end else begin
      mw = v.w2; ma = v.a2; md = v.d2; ow = v.e1 && v.w1; oa = v.a1; od = v.d1;
    end
    if (!wf)              return mem_m[ma];
    if (mw)               return md;
    if (ow && (oa == ma)) return od;
    return mem_m[ma];
  endfunction

  task automatic check_outputs();
    logic [7:0] dv [4];
    logic       vv [4];
    bit         xc;
    dv[0] = do_a1; dv[1] = do_a2; dv[2] = do_b1; dv[3] = do_b2;
    vv[0] = va1;   vv[1] = va2;   vv[2] = vb1;   vv[3] = vb2;
    for (int i = 0; i < 4; i++) begin
      if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
        chk($sformatf("valid dut%0d p%0d", i/2, i%2+1), {31'd0, vv[i]}, 32'd1);
        chk($sformatf("data dut%0d p%0d", i/2, i%2+1), {24'd0, dv[i]}, {24'd0, sbq[i][0].data});
        last[i] = sbq[i][0].data;
        void'(sbq[i].pop_front());
      end else begin
        chk($sformatf("idle valid dut%0d p%0d", i/2, i%2+1), {31'd0, vv[i]}, 32'd0);
        chk($sformatf("hold data dut%0d p%0d", i/2, i%2+1), {24'd0, dv[i]}, {24'd0, last[i]});
      end
    end
    xc = (coll_q.size() > 0 && coll_q[0] == cyc);
    if (xc) void'(coll_q.pop_front());
    chk("collision dut0", {31'd0, coll_a}, {31'd0, xc});
    chk("collision dut1", {31'd0, coll_b}, {31'd0, xc});
    chk("ready dut0", {31'd0, rdy_a}, {31'd0, rel_edges >= DEPTH});
    chk("ready dut1", {31'd0, rdy_b}, {31'd0, rel_edges >= DEPTH});
  endtask

  // Drive one cycle of requests at a negedge, predict, then check at the next negedge.
  task automatic step(input vec_t v, input bit use_tab);
    bit   acc;
    exp_t e;
    acc = (rel_edges >= DEPTH);
    en_1 = v.e1; we_1 = v.w1; addr_1 = v.a1; data_in_1 = v.d1;
    en_2 = v.e2; we_2 = v.w2; addr_2 = v.a2; data_in_2 = v.d2;
    if (acc) begin
      for (int d = 0; d < 2; d++) begin
        if (v.e1) begin
          e.due = cyc + d + 1; e.data = mdl_rd(1, d[0], v);
          sbq[d*2].push_back(e);
        end
        if (v.e2) begin
          e.due = cyc + d + 1;
          e.data = use_tab ? (d == 1 ? v.x2_wf : v.x2_rf) : mdl_rd(2, d[0], v);
          sbq[d*2+1].push_back(e);
        end
      end
      if (use_tab ? v.xcoll : (v.e1 && v.e2 && v.a1 == v.a2 && (v.w1 || v.w2)))
        coll_q.push_back(cyc + 1);
      if (v.e2 && v.w2) mem_m[v.a2] = v.d2;
      if (v.e1 && v.w1) mem_m[v.a1] = v.d1;
    end
    @(negedge clk);
    cyc++;
    rel_edges++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mkv(0,0,0,0, 0,0,0,0, 0,0,0), 0);
  endtask

  // Assert reset at a negedge, check asynchronous clearing, release two cycles later.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst ready dut0", {31'd0, rdy_a}, 32'd0);
    chk("rst ready dut1", {31'd0, rdy_b}, 32'd0);
    chk("rst valid dut0", {30'd0, va1, va2}, 32'd0);
    chk("rst valid dut1", {30'd0, vb1, vb2}, 32'd0);
    chk("rst coll", {30'd0, coll_a, coll_b}, 32'd0);
    chk("rst data dut0", {16'd0, do_a1, do_a2}, 32'd0);
    chk("rst data dut1", {16'd0, do_b1, do_b2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      last[i] = 8'h00;
    end
    coll_q.delete();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hA5;
    rel_edges = 0;
  endtask

  initial begin
    rst = 1'b0;
    en_1 = 0; en_2 = 0; we_1 = 0; we_2 = 0;
    addr_1 = 0; addr_2 = 0; data_in_1 = 0; data_in_2 = 0;

    tab[0]  = mkv(1,1,4'd5,8'h3C, 0,0,4'd0,8'h00, 8'h00,8'h00,0);
    tab[1]  = mkv(0,0,4'd0,8'h00, 1,0,4'd5,8'h00, 8'h3C,8'h3C,0);
    tab[2]  = mkv(1,1,4'd7,8'h11, 0,0,4'd0,8'h00, 8'h00,8'h00,0);
    tab[3]  = mkv(1,1,4'd7,8'h22, 1,0,4'd7,8'h00, 8'h11,8'h22,1);
    tab[4]  = mkv(1,1,4'd3,8'hAA, 1,1,4'd3,8'h55, 8'hA5,8'h55,1);
    tab[5]  = mkv(1,0,4'd3,8'h00, 1,0,4'd3,8'h00, 8'hAA,8'hAA,0);
    tab[6]  = mkv(1,0,4'd9,8'h00, 1,1,4'd9,8'h66, 8'hA5,8'h66,1);
    tab[7]  = mkv(1,0,4'd7,8'h00, 1,0,4'd9,8'h00, 8'h66,8'h66,0);
    tab[8]  = mkv(1,1,4'd2,8'h01, 1,1,4'd2,8'h02, 8'hA5,8'h02,1);
    tab[9]  = mkv(1,1,4'd2,8'h03, 1,0,4'd2,8'h00, 8'h01,8'h03,1);
    tab[10] = mkv(1,0,4'd2,8'h00, 1,0,4'd2,8'h00, 8'h03,8'h03,0);
    tab[11] = mkv(1,1,4'd4,8'h77, 1,1,4'd6,8'h88, 8'hA5,8'h88,0);
    tab[12] = mkv(1,0,4'd4,8'h00, 1,0,4'd6,8'h00, 8'h88,8'h88,0);
    tab[13] = mkv(0,0,4'd0,8'h00, 1,1,4'd1,8'h5A, 8'hA5,8'h5A,0);

    @(negedge clk);
    do_reset();

    // Clear: requests during the clear are ignored, then all words read back INIT.
    for (int i = 0; i < DEPTH; i++) step(mkv(1,1,4'd0,8'hFF, 1,0,4'd1,8'h00, 0,0,0), 0);
    for (int i = 0; i < DEPTH; i++)
      step(mkv(1,0,4'(i),8'h00, 1,0,4'(DEPTH-1-i),8'h00, 0,0,0), 0);
    idle(3);

    for (int i = 0; i < 14; i++) step(tab[i], 1);
    idle(3);

    // Reset from RUN while outputs and collision are active.
    step(mkv(1,0,4'd2,8'h00, 1,1,4'd2,8'h44, 0,0,0), 0);
    do_reset();

    // Reset mid-clear at count 9, with requests to already-cleared words.
    for (int i = 0; i < 9; i++) step(mkv(1,1,4'd0,8'hFF, 1,1,4'd1,8'hEE, 0,0,0), 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(mkv(1,1,4'd0,8'hFF, 1,1,4'd1,8'hEE, 0,0,0), 0);
    for (int i = 0; i < DEPTH; i++)
      step(mkv(1,0,4'(i),8'h00, 1,0,4'(i),8'h00, 0,0,0), 0);
    idle(3);

    for (int i = 0; i < 4; i++) chk($sformatf("scoreboard drained q%0d", i), sbq[i].size(), 0);
    chk("collision queue drained", coll_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
